// File: rtl/wb_regfile_pkg.sv
// Shared encodings for the write-back stage and its register file.
package wb_regfile_pkg;

    localparam int DATA_W_DEF   = 64;
    localparam int REG_ID_W_DEF = 5;
    localparam int REG_NUM      = 1 << REG_ID_W_DEF;

    typedef enum logic [1:0] {
        TYPE_LOAD  = 2'd0,
        TYPE_STORE = 2'd1,
        TYPE_ALU   = 2'd2,
        TYPE_NONE  = 2'd3
    } wb_type_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_DONE  = 2'd2
    } wb_state_e;

    // Only loads and ALU ops produce a register result.
    function automatic logic type_writes(input wb_type_e t);
        return (t == TYPE_LOAD) || (t == TYPE_ALU);
    endfunction

endpackage

// File: rtl/wb_regfile_2r1w.sv
// Two registered read ports, one write port, write-first bypass, x0 tied to zero.
module regfile_2r1w
    import wb_regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int REG_ID_W = REG_ID_W_DEF
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_we,
    input  logic [REG_ID_W-1:0] i_waddr,
    input  logic [DATA_W-1:0]   i_wdata,
    input  logic                i_rd_req,
    input  logic [REG_ID_W-1:0] i_raddr1,
    input  logic [REG_ID_W-1:0] i_raddr2,
    output logic [DATA_W-1:0]   o_rdata1,
    output logic [DATA_W-1:0]   o_rdata2,
    output logic                o_rvalid
);

    localparam int NREG = 1 << REG_ID_W;

    logic [NREG-1:0][DATA_W-1:0] regs;
    logic                        we_eff;
    logic [DATA_W-1:0]           rd1_nxt, rd2_nxt;

    assign we_eff = i_we && (i_waddr != '0);

    // A read colliding with the commit in the same cycle sees the new value.
    always_comb begin
        rd1_nxt = regs[i_raddr1];
        rd2_nxt = regs[i_raddr2];
        if (we_eff && (i_waddr == i_raddr1)) rd1_nxt = i_wdata;
        if (we_eff && (i_waddr == i_raddr2)) rd2_nxt = i_wdata;
        if (i_raddr1 == '0) rd1_nxt = '0;
        if (i_raddr2 == '0) rd2_nxt = '0;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            regs     <= '0;
            o_rdata1 <= '0;
            o_rdata2 <= '0;
            o_rvalid <= 1'b0;
        end else begin
            if (we_eff) regs[i_waddr] <= i_wdata;
            o_rvalid <= i_rd_req;
            if (i_rd_req) begin
                o_rdata1 <= rd1_nxt;
                o_rdata2 <= rd2_nxt;
            end
        end
    end

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage: selects load/ALU result, commits it, then signals completion to fetch.
module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int REG_ID_W = REG_ID_W_DEF
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [DATA_W-1:0]   i_data,
    input  logic [REG_ID_W-1:0] i_rd_id,
    input  logic [1:0]          i_type,
    input  logic                i_valid,
    input  logic [DATA_W-1:0]   i_d_data,
    input  logic                i_rs_req,
    input  logic [REG_ID_W-1:0] i_rs1_id,
    input  logic [REG_ID_W-1:0] i_rs2_id,
    output logic [DATA_W-1:0]   o_rs1_data,
    output logic [DATA_W-1:0]   o_rs2_data,
    output logic                o_rs_valid,
    output logic [REG_ID_W-1:0] o_wb_rd_id,
    output logic [DATA_W-1:0]   o_wb_data,
    output logic                o_valid
);

    wb_state_e           state;
    wb_type_e            type_q;
    logic [REG_ID_W-1:0] rd_q;
    logic [DATA_W-1:0]   val_q;
    logic                we;

    assign we = (state == S_WRITE) && type_writes(type_q);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= S_IDLE;
            type_q     <= TYPE_NONE;
            rd_q       <= '0;
            val_q      <= '0;
            o_valid    <= 1'b0;
            o_wb_rd_id <= '0;
            o_wb_data  <= '0;
        end else begin
            o_valid <= 1'b0;
            case (state)
                S_IDLE: if (i_valid) begin
                    rd_q   <= i_rd_id;
                    type_q <= wb_type_e'(i_type);
                    val_q  <= (wb_type_e'(i_type) == TYPE_LOAD) ? i_d_data : i_data;
                    state  <= S_WRITE;
                end
                // Commit happens combinationally through we; outputs go live for S_DONE.
                S_WRITE: begin
                    o_valid    <= 1'b1;
                    o_wb_rd_id <= rd_q;
                    o_wb_data  <= val_q;
                    state      <= S_DONE;
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    a_valid_only_idle: assert property (@(posedge i_clk) disable iff (i_rst)
        !(i_valid && (state != S_IDLE)));

    regfile_2r1w #(
        .DATA_W   (DATA_W),
        .REG_ID_W (REG_ID_W)
    ) u_rf (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_we     (we),
        .i_waddr  (rd_q),
        .i_wdata  (val_q),
        .i_rd_req (i_rs_req),
        .i_raddr1 (i_rs1_id),
        .i_raddr2 (i_rs2_id),
        .o_rdata1 (o_rs1_data),
        .o_rdata2 (o_rs2_data),
        .o_rvalid (o_rs_valid)
    );

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile with a per-cycle reference model and literal spot checks.
module tb_wb_regfile;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic [63:0] i_data, i_d_data;
    logic [4:0]  i_rd_id, i_rs1_id, i_rs2_id;
    logic [1:0]  i_type;
    logic        i_valid, i_rs_req;
    logic [63:0] o_rs1_data, o_rs2_data, o_wb_data;
    logic [4:0]  o_wb_rd_id;
    logic        o_rs_valid, o_valid;

    int n_chk = 0;
    int n_fail = 0;

    wb_regfile dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_data(i_data), .i_rd_id(i_rd_id),
        .i_type(i_type), .i_valid(i_valid), .i_d_data(i_d_data),
        .i_rs_req(i_rs_req), .i_rs1_id(i_rs1_id), .i_rs2_id(i_rs2_id),
        .o_rs1_data(o_rs1_data), .o_rs2_data(o_rs2_data), .o_rs_valid(o_rs_valid),
        .o_wb_rd_id(o_wb_rd_id), .o_wb_data(o_wb_data), .o_valid(o_valid)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: architectural register contents plus one in-flight instruction.
    logic [63:0] m_regs [32];
    logic        started = 1'b0;
    logic        e_valid, e_rs_valid;
    logic [63:0] e_rs1, e_rs2, e_wb_data;
    logic [4:0]  e_wb_rd;
    logic        p_vld;
    int          p_cyc, cyc, busy_until;
    logic [4:0]  p_rd;
    logic [1:0]  p_type;
    logic [63:0] p_val;

    initial begin
        cyc = 0; busy_until = -10; p_vld = 0;
        forever begin
            @(posedge i_clk);
            if (i_rst) begin
                for (int r = 0; r < 32; r++) m_regs[r] = '0;
                p_vld = 0; busy_until = -10;
                e_valid = 0; e_rs_valid = 0; e_rs1 = '0; e_rs2 = '0;
                e_wb_rd = '0; e_wb_data = '0;
                started = 1'b1;
            end else if (started) begin
                e_valid = 0;
                if (p_vld && cyc == p_cyc + 1) begin
                    if ((p_type == 2'd0 || p_type == 2'd2) && p_rd != 0) m_regs[p_rd] = p_val;
                    e_valid = 1; e_wb_rd = p_rd; e_wb_data = p_val;
                    p_vld = 0; busy_until = cyc + 1;
                end
                e_rs_valid = i_rs_req;
                if (i_rs_req) begin
                    e_rs1 = (i_rs1_id == 0) ? 64'd0 : m_regs[i_rs1_id];
                    e_rs2 = (i_rs2_id == 0) ? 64'd0 : m_regs[i_rs2_id];
                end
                if (i_valid && !p_vld && cyc > busy_until) begin
                    p_vld = 1; p_cyc = cyc; p_rd = i_rd_id; p_type = i_type;
                    p_val = (i_type == 2'd0) ? i_d_data : i_data;
                end
            end
            cyc++;
        end
    end

    always @(negedge i_clk) begin
        if (started) begin
            chk("m_valid", {63'd0, o_valid}, {63'd0, e_valid});
            chk("m_rs_valid", {63'd0, o_rs_valid}, {63'd0, e_rs_valid});
            chk("m_rs1", o_rs1_data, e_rs1);
            chk("m_rs2", o_rs2_data, e_rs2);
            chk("m_wb_rd", {59'd0, o_wb_rd_id}, {59'd0, e_wb_rd});
            chk("m_wb_data", o_wb_data, e_wb_data);
        end
    end

    task automatic step();
        @(posedge i_clk); #1;
    endtask

    task automatic issue(input logic [1:0] t, input logic [4:0] rd,
                         input logic [63:0] d, input logic [63:0] dd);
        i_valid = 1; i_type = t; i_rd_id = rd; i_data = d; i_d_data = dd;
        step();
        i_valid = 0;
    endtask

    // Issue, then check the o_valid pulse lands exactly one cycle later and lasts one cycle.
    task automatic issue_done(input string nm, input logic [1:0] t, input logic [4:0] rd,
                              input logic [63:0] d, input logic [63:0] dd, input logic [63:0] exp_wb);
        issue(t, rd, d, dd);
        chk({nm, "_early"}, {63'd0, o_valid}, 64'd0);
        step();
        chk({nm, "_valid"}, {63'd0, o_valid}, 64'd1);
        chk({nm, "_wbdata"}, o_wb_data, exp_wb);
        chk({nm, "_wbrd"}, {59'd0, o_wb_rd_id}, {59'd0, rd});
        step();
        chk({nm, "_drop"}, {63'd0, o_valid}, 64'd0);
    endtask

    task automatic rd_chk(input string nm, input logic [4:0] r1, input logic [4:0] r2,
                          input logic [63:0] x1, input logic [63:0] x2);
        i_rs_req = 1; i_rs1_id = r1; i_rs2_id = r2;
        step();
        i_rs_req = 0;
        chk({nm, "_rsv"}, {63'd0, o_rs_valid}, 64'd1);
        chk({nm, "_rs1"}, o_rs1_data, x1);
        chk({nm, "_rs2"}, o_rs2_data, x2);
    endtask

    initial begin
        i_rst = 1; i_valid = 0; i_rs_req = 0; i_type = 0; i_rd_id = 0;
        i_data = 0; i_d_data = 0; i_rs1_id = 0; i_rs2_id = 0;
        step(); step();
        i_rst = 0;
        chk("rst_valid", {63'd0, o_valid}, 64'd0);
        chk("rst_rsv", {63'd0, o_rs_valid}, 64'd0);
        chk("rst_wbdata", o_wb_data, 64'd0);
        for (int r = 1; r < 32; r += 2)
            rd_chk("rst_read", r[4:0], 5'(r + 1), 64'd0, 64'd0);
        step();
        chk("idle_rsv", {63'd0, o_rs_valid}, 64'd0);

        issue_done("alu", 2'd2, 5'd5, 64'h1234, 64'h9999, 64'h1234);
        rd_chk("alu_rd", 5'd5, 5'd0, 64'h1234, 64'd0);

        issue_done("load", 2'd0, 5'd7, 64'h80, 64'hDEADBEEF, 64'hDEADBEEF);
        rd_chk("load_rd", 5'd7, 5'd5, 64'hDEADBEEF, 64'h1234);
        step();
        chk("hold_rs1", o_rs1_data, 64'hDEADBEEF);

        issue_done("store", 2'd1, 5'd3, 64'hAAAA, 64'hBBBB, 64'hAAAA);
        issue_done("none", 2'd3, 5'd4, 64'hCCCC, 64'hDDDD, 64'hCCCC);
        issue_done("x0", 2'd2, 5'd0, 64'hFF, 64'h0, 64'hFF);
        step(); step();
        chk("hold_wbdata", o_wb_data, 64'hFF);
        rd_chk("nowr_34", 5'd3, 5'd4, 64'd0, 64'd0);
        rd_chk("nowr_0", 5'd0, 5'd0, 64'd0, 64'd0);

        // Back-to-back: the second valid lands at t+3, the first cycle the stage is idle again.
        issue(2'd2, 5'd12, 64'h100, 64'h0);
        step(); step();
        issue(2'd2, 5'd13, 64'h200, 64'h0);
        step();
        chk("b2b_valid", {63'd0, o_valid}, 64'd1);
        chk("b2b_wb", o_wb_data, 64'h200);
        step();
        rd_chk("b2b_rd", 5'd12, 5'd13, 64'h100, 64'h200);

        issue_done("byp_pre", 2'd2, 5'd9, 64'h11, 64'h0, 64'h11);
        issue(2'd2, 5'd9, 64'h22, 64'h0);
        rd_chk("bypass", 5'd9, 5'd0, 64'h22, 64'd0);
        chk("byp_valid", {63'd0, o_valid}, 64'd1);
        step();

        issue(2'd2, 5'd6, 64'h55, 64'h0);
        i_rst = 1;
        step();
        i_rst = 0;
        chk("midrst_v0", {63'd0, o_valid}, 64'd0);
        step();
        chk("midrst_v1", {63'd0, o_valid}, 64'd0);
        rd_chk("midrst_rd", 5'd6, 5'd5, 64'd0, 64'd0);
        step(); step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Write-back stage plus integer register file, directly downstream of the memory stage.
- Consumes the memory stage's result: ALU result or address, destination register id, instruction type and valid pulse, plus the data-memory read bus.
- Commits the selected value into a 32 x 64-bit register file, then pulses an instruction-done valid back to fetch.
- Provides a two-operand, registered read port to decode.

Parameters:
- DATA_W, 64, width of register and data values.
- REG_ID_W, 5, register-id width (2^REG_ID_W registers).

Ports:
- i_clk  input  1  clock; all logic on posedge.
- i_rst  input  1  synchronous, active-high reset.
- i_data  input  DATA_W  ALU result/address from memory stage.
- i_rd_id  input  REG_ID_W  destination register.
- i_type  input  2  0=load, 1=store, 2=ALU writeback, 3=no-writeback (branch/nop).
- i_valid  input  1  one-cycle pulse qualifying i_data/i_rd_id/i_type.
- i_d_data  input  DATA_W  data-memory read data, stable while i_valid is high.
- i_rs_req  input  1  operand read request from decode.
- i_rs1_id  input  REG_ID_W  source register 1.
- i_rs2_id  input  REG_ID_W  source register 2.
- o_rs1_data  output  DATA_W  register read data 1.
- o_rs2_data  output  DATA_W  register read data 2.
- o_rs_valid  output  1  read data valid pulse.
- o_wb_rd_id  output  REG_ID_W  register id committed by the last instruction.
- o_wb_data  output  DATA_W  value committed (or would-be value for store/nop).
- o_valid  output  1  instruction-complete pulse to fetch.

Behaviour:
- Reset (synchronous, i_rst=1 at posedge):
  - all 32 registers = 0; state = S_IDLE.
  - o_valid, o_rs_valid = 0; o_rs1_data, o_rs2_data, o_wb_rd_id, o_wb_data = 0.
  - Reset mid-operation abandons the instruction: no register write, no o_valid.
- State machine:
  - S_IDLE: on i_valid, latch rd_id and type; wb value = i_d_data if type==0, else i_data; go to S_WRITE. Without i_valid, stay.
  - S_WRITE: if type in {0,2} and rd_id != 0, write regs[rd_id] = latched value. Go to S_DONE.
  - S_DONE: o_valid = 1 for exactly this cycle; o_wb_rd_id and o_wb_data show the latched values. Go to S_IDLE.
- Latency: i_valid in cycle t -> register updated at end of t+1 -> o_valid high in cycle t+2. Back-to-back i_valid is accepted from cycle t+3.
- i_valid outside S_IDLE is ignored; upstream never issues it there, and an assertion flags it.
- x0: writes are discarded; reads always return 0.
- Store and type-3 instructions still sequence through S_WRITE/S_DONE and pulse o_valid, with no write.
- o_wb_rd_id and o_wb_data hold their value after S_DONE until the next instruction reaches S_DONE.
- Read port:
  - i_rs_req sampled in cycle t -> o_rs1_data, o_rs2_data registered and o_rs_valid=1 in cycle t+1. o_rs_valid is 0 otherwise.
  - Data outputs hold their last value when no request is made.
  - Write-first bypass: if a request in cycle t coincides with S_WRITE committing rd_id == rs id (nonzero), return the new value.
  - Reads are independent of the write state machine and accepted in any state.
- Widths: no sign/zero extension; values pass through at DATA_W.

Decomposition:
- Shared package:
  - type encodings TYPE_LOAD=0, TYPE_STORE=1, TYPE_ALU=2, TYPE_NONE=3.
  - state encodings S_IDLE/S_WRITE/S_DONE.
  - REG_NUM = 1<<REG_ID_W.
- One sub-module, regfile_2r1w:
  - 2 registered read ports, 1 write port, write-first bypass, x0 hardwired to zero.
  - Wrapper holds the write-back FSM and source select.

Test Plan:
- Reset: hold i_rst 2 cycles, then read x1..x31 -> all 0, o_valid=0, o_rs_valid=0.
- ALU writeback: i_valid, type=2, rd=5, i_data=0x1234 at t -> o_valid only at t+2, o_wb_data=0x1234; read x5 -> 0x1234.
- Load select: type=0, rd=7, i_data=0x80, i_d_data=0xDEADBEEF -> x7=0xDEADBEEF, not 0x80.
- Store, type 3, and x0: type=1 rd=3; type=3 rd=4; type=2 rd=0 data=0xFF -> o_valid pulses each time; x3, x4, x0 remain 0.
- Bypass: x9=0x11, then writeback rd=9 data=0x22, with i_rs_req rs1=9 rs2=0 in the S_WRITE cycle -> o_rs1_data=0x22, o_rs2_data=0 next cycle.
- Reset mid-op: i_valid type=2 rd=6 data=0x55, i_rst at t+1 -> x6=0, no o_valid pulse.
